// File: rtl/sd_card_pkg.sv
// rtl/sd_card_pkg.sv - shared encodings and constants for the SD card CMD-line responder
package sd_card_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WAIT_NCR,
    ST_SEND
  } state_e;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD2  = 6'd2;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD9  = 6'd9;
  localparam logic [5:0] CMD10 = 6'd10;
  localparam logic [5:0] CMD41 = 6'd41;

  localparam logic [7:0] RESP_LEN_SHORT = 8'd48;
  localparam logic [7:0] RESP_LEN_LONG  = 8'd136;

  // first frame bit position occupied by the CRC7 field in 48-bit frames
  localparam logic [7:0] CRC_START = 8'd40;

  localparam int COM_CRC_ERR_BIT = 23;

endpackage

// File: rtl/sd_card_cmd_responder_if.sv
// rtl/sd_card_cmd_responder_if.sv - SD CMD pad bundle between host controller and card model
interface sd_card_cmd_responder_if;
  logic sd_clk_i;
  logic sd_cmd_i;
  logic sd_cmd_o;
  logic sd_cmd_oe_o;

  modport master (output sd_clk_i, output sd_cmd_i, input sd_cmd_o, input sd_cmd_oe_o);
  modport slave  (input sd_clk_i, input sd_cmd_i, output sd_cmd_o, output sd_cmd_oe_o);
endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7 + x^3 + 1) with clear and enable
module sd_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  // next remainder: clear wins over shifting in a new bit
  always_comb begin
    fb    = bit_in ^ crc_q[6];
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end

  // remainder register
  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - card-side CMD line: receive 48-bit command, check CRC7, send R1/R2/R3/R7
module sd_card_cmd_responder
  import sd_card_pkg::*;
#(
  parameter int unsigned  NCR    = 2,
  parameter logic [31:0]  OCR    = 32'h80FF8000,
  parameter logic [127:0] CID    = 128'h0,
  parameter logic [31:0]  STATUS = 32'h00000900
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  sd_card_cmd_responder_if.slave   sd,
  output logic                     cmd_valid_o,
  output logic [5:0]               cmd_index_o,
  output logic [31:0]              cmd_arg_o,
  output logic                     crc_err_o
);

  localparam logic [6:0] NCR_CNT = 7'(NCR);

  state_e        state_q, state_d;
  logic          sd_clk_s1_q, sd_clk_s1_d, sd_clk_s2_q, sd_clk_s2_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [46:0]   rx_sr_q, rx_sr_d;
  logic [135:0]  resp_q, resp_d;
  logic [7:0]    resp_len_q, resp_len_d;
  logic          crc_ins_q, crc_ins_d;
  logic [6:0]    ncr_cnt_q, ncr_cnt_d;
  logic          cmd_o_q, cmd_o_d, oe_q, oe_d;
  logic          cmd_valid_q, cmd_valid_d, crc_err_q, crc_err_d;
  logic          com_crc_err_q, com_crc_err_d;
  logic [5:0]    cmd_index_q, cmd_index_d;
  logic [31:0]   cmd_arg_q, cmd_arg_d;

  logic          rise, fall, tx_bit, crc_slot, rx_good;
  logic [7:0]    cnt_inc, tx_pos;
  logic [2:0]    crc_sel;
  logic          rx_crc_clr, rx_crc_en, tx_crc_clr, tx_crc_en;
  logic [6:0]    rx_crc, tx_crc;
  logic [5:0]    rx_index;
  logic [31:0]   rx_arg, status_w;

  sd_crc7 u_rx_crc (
    .clk(wb_clk_i), .rst(wb_rst_i), .clr(rx_crc_clr), .en(rx_crc_en),
    .bit_in(sd.sd_cmd_i), .crc_o(rx_crc)
  );

  sd_crc7 u_tx_crc (
    .clk(wb_clk_i), .rst(wb_rst_i), .clr(tx_crc_clr), .en(tx_crc_en),
    .bit_in(tx_bit), .crc_o(tx_crc)
  );

  // sd_clk edge strobes, decoded command fields and the next response bit to drive
  always_comb begin
    rise     = sd_clk_s1_q & ~sd_clk_s2_q;
    fall     = ~sd_clk_s1_q & sd_clk_s2_q;
    cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    rx_index = rx_sr_q[45:40];
    rx_arg   = rx_sr_q[39:8];
    rx_good  = rx_sr_q[46] & (rx_sr_q[7:1] == rx_crc) & rx_sr_q[0];
    // position of the bit about to be driven: 0 on leaving WAIT_NCR, else one past the current bit
    tx_pos   = (state_q == ST_SEND) ? cnt_inc : 8'd0;
    crc_slot = crc_ins_q && (tx_pos >= CRC_START) && (tx_pos < CRC_START + 8'd7);
    crc_sel  = 3'(8'd46 - tx_pos);
    tx_bit   = crc_slot ? tx_crc[crc_sel] : resp_q[8'd135 - tx_pos];
    status_w = STATUS;
    status_w[COM_CRC_ERR_BIT] = STATUS[COM_CRC_ERR_BIT] | com_crc_err_q;
  end

  // command/response sequencer
  always_comb begin
    sd_clk_s1_d   = sd.sd_clk_i;
    sd_clk_s2_d   = sd_clk_s1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_sr_d       = rx_sr_q;
    resp_d        = resp_q;
    resp_len_d    = resp_len_q;
    crc_ins_d     = crc_ins_q;
    ncr_cnt_d     = ncr_cnt_q;
    cmd_o_d       = cmd_o_q;
    oe_d          = oe_q;
    com_crc_err_d = com_crc_err_q;
    cmd_index_d   = cmd_index_q;
    cmd_arg_d     = cmd_arg_q;
    cmd_valid_d   = 1'b0;
    crc_err_d     = 1'b0;
    rx_crc_clr    = 1'b0;
    rx_crc_en     = 1'b0;
    tx_crc_clr    = 1'b0;
    tx_crc_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rx_crc_clr = 1'b1;
        if (rise && !sd.sd_cmd_i) begin
          rx_crc_clr = 1'b0;
          rx_crc_en  = 1'b1;
          rx_sr_d    = '0;
          cnt_d      = 8'd1;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rise) begin
          rx_sr_d   = {rx_sr_q[45:0], sd.sd_cmd_i};
          rx_crc_en = (cnt_q < CRC_START);
          cnt_d     = cnt_inc;
          if (cnt_inc == RESP_LEN_SHORT) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (rx_good) begin
          cmd_valid_d = 1'b1;
          cmd_index_d = rx_index;
          cmd_arg_d   = rx_arg;
          if (rx_index != CMD0) begin
            state_d    = ST_WAIT_NCR;
            ncr_cnt_d  = '0;
            tx_crc_clr = 1'b1;
            resp_len_d = RESP_LEN_SHORT;
            crc_ins_d  = 1'b1;
            case (rx_index)
              CMD2, CMD9, CMD10: begin
                resp_d     = {2'b00, 6'h3F, CID[127:1], 1'b1};
                resp_len_d = RESP_LEN_LONG;
                crc_ins_d  = 1'b0;
              end
              CMD8: resp_d = {2'b00, CMD8, 20'h0, rx_arg[11:0], 7'h00, 1'b1, 88'h0};
              CMD41: begin
                resp_d    = {2'b00, 6'h3F, OCR, 7'h7F, 1'b1, 88'h0};
                crc_ins_d = 1'b0;
              end
              default: begin
                // sticky error is reported once, in the R1 frame snapshot taken here
                resp_d        = {2'b00, rx_index, status_w, 7'h00, 1'b1, 88'h0};
                com_crc_err_d = 1'b0;
              end
            endcase
          end
        end else begin
          crc_err_d     = 1'b1;
          com_crc_err_d = 1'b1;
        end
      end
      ST_WAIT_NCR: begin
        if (fall) begin
          if (ncr_cnt_q == NCR_CNT) begin
            state_d   = ST_SEND;
            cnt_d     = 8'd0;
            oe_d      = 1'b1;
            cmd_o_d   = tx_bit;
            tx_crc_en = 1'b1;
          end else begin
            ncr_cnt_d = ncr_cnt_q + 7'd1;
          end
        end
      end
      ST_SEND: begin
        if (fall) begin
          if (cnt_q == resp_len_q - 8'd1) begin
            oe_d    = 1'b0;
            cmd_o_d = 1'b1;
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d     = cnt_inc;
            cmd_o_d   = tx_bit;
            tx_crc_en = (tx_pos < CRC_START);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      sd_clk_s1_q   <= 1'b0;
      sd_clk_s2_q   <= 1'b0;
      cnt_q         <= '0;
      rx_sr_q       <= '0;
      resp_q        <= '0;
      resp_len_q    <= RESP_LEN_SHORT;
      crc_ins_q     <= 1'b0;
      ncr_cnt_q     <= '0;
      cmd_o_q       <= 1'b1;
      oe_q          <= 1'b0;
      cmd_valid_q   <= 1'b0;
      crc_err_q     <= 1'b0;
      com_crc_err_q <= 1'b0;
      cmd_index_q   <= '0;
      cmd_arg_q     <= '0;
    end else begin
      state_q       <= state_d;
      sd_clk_s1_q   <= sd_clk_s1_d;
      sd_clk_s2_q   <= sd_clk_s2_d;
      cnt_q         <= cnt_d;
      rx_sr_q       <= rx_sr_d;
      resp_q        <= resp_d;
      resp_len_q    <= resp_len_d;
      crc_ins_q     <= crc_ins_d;
      ncr_cnt_q     <= ncr_cnt_d;
      cmd_o_q       <= cmd_o_d;
      oe_q          <= oe_d;
      cmd_valid_q   <= cmd_valid_d;
      crc_err_q     <= crc_err_d;
      com_crc_err_q <= com_crc_err_d;
      cmd_index_q   <= cmd_index_d;
      cmd_arg_q     <= cmd_arg_d;
    end
  end

  assign sd.sd_cmd_o    = cmd_o_q;
  assign sd.sd_cmd_oe_o = oe_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign crc_err_o      = crc_err_q;
  assign cmd_index_o    = cmd_index_q;
  assign cmd_arg_o      = cmd_arg_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb/tb_sd_card_cmd_responder.sv - scoreboard bench for the SD card CMD-line responder
module tb_sd_card_cmd_responder;

  localparam logic [127:0] TB_CID    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [31:0]  TB_OCR    = 32'h80FF8000;
  localparam logic [31:0]  TB_STATUS = 32'h00000900;
  localparam int           TB_NCR    = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        sd_clk   = 1'b0;
  logic        host_cmd = 1'b1;
  logic        cmd_valid_o, crc_err_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;

  sd_card_cmd_responder_if sd_if ();
  assign sd_if.sd_clk_i = sd_clk;
  // resolved CMD pad: card wins while it drives, otherwise host (idle high)
  assign sd_if.sd_cmd_i = sd_if.sd_cmd_oe_o ? sd_if.sd_cmd_o : host_cmd;

  sd_card_cmd_responder #(
    .NCR(TB_NCR), .OCR(TB_OCR), .CID(TB_CID), .STATUS(TB_STATUS)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .sd          (sd_if),
    .cmd_valid_o (cmd_valid_o),
    .cmd_index_o (cmd_index_o),
    .cmd_arg_o   (cmd_arg_o),
    .crc_err_o   (crc_err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  initial begin
    #3;
    forever #50 sd_clk = ~sd_clk;
  end

  typedef struct {
    logic        is_err;
    logic [5:0]  idx;
    logic [31:0] arg;
  } evt_t;

  typedef struct {
    logic [135:0] bits;
    int           len;
  } frm_t;

  evt_t evt_q[$];
  frm_t frm_q[$];

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int end_rise = 0;
  logic in_frame = 1'b0;
  logic rst_seen = 1'b0;
  logic [135:0] rx_bits;
  int rx_len;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic push_evt(input logic is_err, input logic [5:0] idx, input logic [31:0] arg);
    evt_t e;
    e.is_err = is_err;
    e.idx    = idx;
    e.arg    = arg;
    evt_q.push_back(e);
  endtask

  task automatic push_frm(input logic [135:0] bits, input int len);
    frm_t f;
    f.bits = bits;
    f.len  = len;
    frm_q.push_back(f);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    logic [47:0] f;
    f = {2'b01, idx, arg, crc, 1'b1};
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      host_cmd = f[i];
      if (i == 0) end_rise = rise_cnt + 1;
    end
    @(negedge sd_clk);
    host_cmd = 1'b1;
  endtask

  task automatic wait_resp_done(input string name);
    int n;
    n = 0;
    while ((frm_q.size() != 0 || in_frame) && n < 20000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check({name, "_resp_timeout"}, 136'(n >= 20000), 136'(0));
    repeat (2) @(negedge sd_clk);
  endtask

  task automatic no_resp_check(input string name);
    repeat (8) @(negedge sd_clk);
    check({name, "_oe"}, 136'(sd_if.sd_cmd_oe_o), 136'(0));
    check({name, "_evt_drained"}, 136'(evt_q.size()), 136'(0));
  endtask

  // command-event monitor: every valid/error pulse consumes one expected event
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && (cmd_valid_o || crc_err_o)) begin
      if (evt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b, expected none", cmd_valid_o, crc_err_o);
      end else begin
        evt_t e;
        e = evt_q.pop_front();
        check("evt_crc_err", 136'(crc_err_o), 136'(e.is_err));
        check("evt_cmd_valid", 136'(cmd_valid_o), 136'(!e.is_err));
        if (!e.is_err) begin
          check("evt_cmd_index", 136'(cmd_index_o), 136'(e.idx));
          check("evt_cmd_arg", 136'(cmd_arg_o), 136'(e.arg));
        end
      end
    end
  end

  // response monitor: collect card-driven bits at sd_clk rises, compare when oe drops
  always @(posedge sd_clk) begin
    rise_cnt++;
    if (sd_if.sd_cmd_oe_o) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        rx_len   = 0;
        rx_bits  = '0;
        // end bit, NCR idle periods, then the start bit
        check("ncr_latency", 136'(rise_cnt - end_rise), 136'(TB_NCR + 1));
      end
      rx_bits = {rx_bits[134:0], sd_if.sd_cmd_o};
      rx_len++;
    end else if (in_frame) begin
      in_frame = 1'b0;
      if (frm_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0d bits, expected none", rx_len);
      end else begin
        frm_t f;
        f = frm_q.pop_front();
        if (rst_seen) begin
          rst_seen = 1'b0;
        end else begin
          check("resp_len", 136'(rx_len), 136'(f.len));
          check("resp_bits", rx_bits, f.bits);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] h;
    int n;

    wb_rst_i = 1'b1;
    repeat (4) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_cmd_o", 136'(sd_if.sd_cmd_o), 136'(1));
    check("rst_oe", 136'(sd_if.sd_cmd_oe_o), 136'(0));
    check("rst_valid", 136'(cmd_valid_o), 136'(0));
    check("rst_crc_err", 136'(crc_err_o), 136'(0));
    check("rst_index", 136'(cmd_index_o), 136'(0));
    check("rst_arg", 136'(cmd_arg_o), 136'(0));
    wb_rst_i = 1'b0;
    repeat (3) @(negedge sd_clk);

    // CMD0: accepted, never answered
    push_evt(1'b0, 6'd0, 32'h0);
    send_cmd(6'd0, 32'h0, 7'h4A);
    no_resp_check("cmd0");

    // CMD8: R7 echoes check pattern with its own CRC7
    h = {2'b00, 6'd8, 32'h000001AA};
    push_evt(1'b0, 6'd8, 32'h000001AA);
    push_frm({88'h0, h, crc7(h), 1'b1}, 48);
    send_cmd(6'd8, 32'h000001AA, 7'h43);
    wait_resp_done("cmd8");

    // CMD41: R3 carries OCR and an all-ones CRC field
    push_evt(1'b0, 6'd41, 32'h40FF8000);
    push_frm({88'h0, 2'b00, 6'h3F, TB_OCR, 7'h7F, 1'b1}, 48);
    send_cmd(6'd41, 32'h40FF8000, crc7({2'b01, 6'd41, 32'h40FF8000}));
    wait_resp_done("cmd41");

    // CMD2: 136-bit R2 with CID[127:1]
    push_evt(1'b0, 6'd2, 32'h0);
    push_frm({2'b00, 6'h3F, TB_CID[127:1], 1'b1}, 136);
    send_cmd(6'd2, 32'h0, crc7({2'b01, 6'd2, 32'h0}));
    wait_resp_done("cmd2");

    // CMD13 with corrupted CRC: error pulse only
    push_evt(1'b1, 6'd0, 32'h0);
    send_cmd(6'd13, 32'h00010000, crc7({2'b01, 6'd13, 32'h00010000}) ^ 7'h01);
    no_resp_check("cmd13_bad");

    // good CMD13 reports the sticky COM_CRC_ERR once
    h = {2'b00, 6'd13, 32'h00800900};
    push_evt(1'b0, 6'd13, 32'h00010000);
    push_frm({88'h0, h, crc7(h), 1'b1}, 48);
    send_cmd(6'd13, 32'h00010000, crc7({2'b01, 6'd13, 32'h00010000}));
    wait_resp_done("cmd13_err");

    h = {2'b00, 6'd13, 32'h00000900};
    push_evt(1'b0, 6'd13, 32'h00010000);
    push_frm({88'h0, h, crc7(h), 1'b1}, 48);
    send_cmd(6'd13, 32'h00010000, crc7({2'b01, 6'd13, 32'h00010000}));
    wait_resp_done("cmd13_clean");

    // reset in the middle of a response
    push_evt(1'b0, 6'd13, 32'h00020000);
    push_frm({88'h0, h, crc7(h), 1'b1}, 48);
    send_cmd(6'd13, 32'h00020000, crc7({2'b01, 6'd13, 32'h00020000}));
    n = 0;
    while (!sd_if.sd_cmd_oe_o && n < 5000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("abort_oe_timeout", 136'(n >= 5000), 136'(0));
    repeat (20) @(posedge sd_clk);
    rst_seen = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    check("abort_oe", 136'(sd_if.sd_cmd_oe_o), 136'(0));
    check("abort_cmd_o", 136'(sd_if.sd_cmd_o), 136'(1));
    check("abort_index", 136'(cmd_index_o), 136'(0));
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wait_resp_done("abort");

    // CMD0 after reset is accepted normally
    push_evt(1'b0, 6'd0, 32'h0);
    send_cmd(6'd0, 32'h0, 7'h4A);
    no_resp_check("cmd0_after_rst");

    check("frames_drained", 136'(frm_q.size()), 136'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
